hwpe_ctrl_context_mgr: RTL and testbench

Context and access manager placed directly upstream of the HWPE control register file. It terminates the peripheral target port and decodes each access into the register-file strobes and flags. It owns the offload lock, the context pointers and occupancy, and the engine start/done sequencing. The register file consumes its `wren/rden/addr/wdata/be/src` outputs and the `is_*`, `*_context` and `true_done` flags.

---
 rtl/hwpe_ctrl_context_mgr.sv | 191 +++++++++++++++++++
 tb/tb_hwpe_ctrl_context_mgr.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_context_mgr.sv
// Access decoder, offload lock, context pointers and engine start/done sequencing in front of the HWPE register file.
// Optional feature: define HWPE_CTRL_CTX_MGR_OWNER_CHECK_EN to restrict contexted writes and TRIGGER to the lock owner.
module hwpe_ctrl_context_mgr #(
    parameter  int unsigned N_CONTEXT        = 2,
    parameter  int unsigned ID_WIDTH         = 16,
    parameter  int unsigned N_MANDATORY_REGS = 7,
    parameter  int unsigned FIRST_IO_REG     = 16,
    localparam int unsigned LOG_CONTEXT      = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic                     wen_i,
    input  logic [11:0]              addr_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               be_i,
    input  logic [ID_WIDTH-1:0]      id_i,
    output logic                     r_valid_o,
    output logic [ID_WIDTH-1:0]      r_id_o,
    output logic                     rf_wren_o,
    output logic                     rf_rden_o,
    output logic [5+LOG_CONTEXT-1:0] rf_addr_o,
    output logic [31:0]              rf_wdata_o,
    output logic [3:0]               rf_be_o,
    output logic [ID_WIDTH-1:0]      rf_src_o,
    output logic                     is_read_o,
    output logic                     is_testset_o,
    output logic                     is_trigger_o,
    output logic                     is_mandatory_o,
    output logic                     is_contexted_o,
    output logic                     is_critical_o,
    output logic                     full_context_o,
    output logic [LOG_CONTEXT-1:0]   pointer_context_o,
    output logic [LOG_CONTEXT-1:0]   running_context_o,
    output logic                     true_done_o,
    output logic                     start_o,
    input  logic                     done_i,
    output logic                     evt_o
);

    localparam logic [4:0]           MAND_IDX  = 5'(N_MANDATORY_REGS);
    localparam logic [4:0]           IO_IDX    = 5'(FIRST_IO_REG);
    localparam logic [LOG_CONTEXT:0] OCC_FULL  = (LOG_CONTEXT+1)'(N_CONTEXT);

    typedef enum logic [1:0] {IDLE, START, RUNNING, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    locked_q;
    logic [ID_WIDTH-1:0]     owner_q;
    logic [LOG_CONTEXT:0]    occupied_q;
    logic [LOG_CONTEXT-1:0]  pointer_q, running_q;
    logic                    r_valid_p1;
    logic [ID_WIDTH-1:0]     r_id_p1;

    logic                    access, write, full;
    logic [4:0]              idx;
    logic [LOG_CONTEXT-1:0]  ctx_field, ctx_sel;
    logic                    ctx_reg, acquire, trigger, owner_match;
    logic                    acquire_ok, trigger_ok, job_done, start, true_done;
    logic                    unused_addr;

    // Wrapping context increment; N_CONTEXT is a power of two but 1 must also wrap to 0.
    function automatic logic [LOG_CONTEXT-1:0] next_ctx(input logic [LOG_CONTEXT-1:0] p);
        if (p == LOG_CONTEXT'(N_CONTEXT - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign gnt_o       = req_i;
    assign access      = req_i;
    assign write       = access & ~wen_i;
    assign idx         = addr_i[6:2];
    assign ctx_field   = addr_i[7+LOG_CONTEXT-1:7];
    assign unused_addr = ^{addr_i[1:0], addr_i[11:7+LOG_CONTEXT]};

    assign ctx_reg     = (idx >= IO_IDX);
    assign acquire     = access & wen_i & (idx == 5'd1);
    assign trigger     = write & (idx == 5'd0);
    assign full        = (occupied_q == OCC_FULL);
    assign owner_match = locked_q & (id_i == owner_q);

    assign is_read_o      = access & wen_i;
    assign is_testset_o   = acquire;
    assign is_trigger_o   = trigger;
    assign is_mandatory_o = access & (idx < MAND_IDX);
    assign is_contexted_o = access & ctx_reg;
    assign is_critical_o  = acquire & locked_q;
    assign full_context_o = full;

    assign acquire_ok = acquire & ~locked_q & ~full;

`ifdef HWPE_CTRL_CTX_MGR_OWNER_CHECK_EN
    // Only the lock owner may program contexted registers or launch the job.
    assign trigger_ok = trigger & owner_match & ~full;
    assign rf_wren_o  = write & ~((ctx_reg | trigger) & ~owner_match);
`else
    logic unused_owner;
    assign unused_owner = owner_match;
    assign trigger_ok   = trigger & ~full;
    assign rf_wren_o    = write;
`endif

    assign rf_rden_o  = access & wen_i;
    assign ctx_sel    = ctx_reg ? pointer_q : ctx_field;
    assign rf_addr_o  = {ctx_sel, idx};
    assign rf_wdata_o = wdata_i;
    assign rf_be_o    = be_i;
    assign rf_src_o   = id_i;

    assign job_done = (state_q == DONE) && (occupied_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked_q   <= 1'b0;
            owner_q    <= '0;
            occupied_q <= '0;
            pointer_q  <= '0;
            running_q  <= '0;
        end else if (clear_i) begin
            locked_q   <= 1'b0;
            owner_q    <= '0;
            occupied_q <= '0;
            pointer_q  <= '0;
            running_q  <= '0;
        end else begin
            if (acquire_ok) begin
                locked_q <= 1'b1;
                owner_q  <= id_i;
            end else if (trigger_ok) begin
                locked_q <= 1'b0;
            end
            if (trigger_ok) pointer_q <= next_ctx(pointer_q);
            if (job_done)   running_q <= next_ctx(running_q);
            // A launch and a retirement in the same cycle cancel out.
            case ({trigger_ok, job_done})
                2'b10:   occupied_q <= occupied_q + 1'b1;
                2'b01:   occupied_q <= occupied_q - 1'b1;
                default: occupied_q <= occupied_q;
            endcase
        end
    end

    // Response stage: one cycle after every granted access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_p1 <= 1'b0;
            r_id_p1    <= '0;
        end else if (clear_i) begin
            r_valid_p1 <= 1'b0;
            r_id_p1    <= '0;
        end else begin
            r_valid_p1 <= access;
            if (access) r_id_p1 <= id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        true_done = 1'b0;
        case (state_q)
            IDLE:    if (occupied_q != '0) state_d = START;
            START: begin
                start   = 1'b1;
                state_d = RUNNING;
            end
            RUNNING: if (done_i) state_d = DONE;
            DONE: begin
                true_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_o           = start;
    assign true_done_o       = true_done;
    assign evt_o             = true_done;
    assign r_valid_o         = r_valid_p1;
    assign r_id_o            = r_id_p1;
    assign pointer_context_o = pointer_q;
    assign running_context_o = running_q;

endmodule

// File: tb/tb_hwpe_ctrl_context_mgr.sv
// Directed bench for hwpe_ctrl_context_mgr: decode, lock, occupancy, remap and start/done sequencing (N_CONTEXT = 2).
module tb_hwpe_ctrl_context_mgr;

    localparam int ID_WIDTH = 16;
    localparam int LOG_CONTEXT = 1;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     clear_i, req_i, wen_i, done_i;
    logic [11:0]              addr_i;
    logic [31:0]              wdata_i;
    logic [3:0]               be_i;
    logic [ID_WIDTH-1:0]      id_i;
    logic                     gnt_o, r_valid_o, rf_wren_o, rf_rden_o;
    logic [ID_WIDTH-1:0]      r_id_o, rf_src_o;
    logic [5+LOG_CONTEXT-1:0] rf_addr_o;
    logic [31:0]              rf_wdata_o;
    logic [3:0]               rf_be_o;
    logic                     is_read_o, is_testset_o, is_trigger_o, is_mandatory_o;
    logic                     is_contexted_o, is_critical_o, full_context_o;
    logic [LOG_CONTEXT-1:0]   pointer_context_o, running_context_o;
    logic                     true_done_o, start_o, evt_o;

    int n_checks = 0;
    int n_pass   = 0;

    hwpe_ctrl_context_mgr #(
        .N_CONTEXT       (2),
        .ID_WIDTH        (ID_WIDTH),
        .N_MANDATORY_REGS(7),
        .FIRST_IO_REG    (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .req_i            (req_i),
        .gnt_o            (gnt_o),
        .wen_i            (wen_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .be_i             (be_i),
        .id_i             (id_i),
        .r_valid_o        (r_valid_o),
        .r_id_o           (r_id_o),
        .rf_wren_o        (rf_wren_o),
        .rf_rden_o        (rf_rden_o),
        .rf_addr_o        (rf_addr_o),
        .rf_wdata_o       (rf_wdata_o),
        .rf_be_o          (rf_be_o),
        .rf_src_o         (rf_src_o),
        .is_read_o        (is_read_o),
        .is_testset_o     (is_testset_o),
        .is_trigger_o     (is_trigger_o),
        .is_mandatory_o   (is_mandatory_o),
        .is_contexted_o   (is_contexted_o),
        .is_critical_o    (is_critical_o),
        .full_context_o   (full_context_o),
        .pointer_context_o(pointer_context_o),
        .running_context_o(running_context_o),
        .true_done_o      (true_done_o),
        .start_o          (start_o),
        .done_i           (done_i),
        .evt_o            (evt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus(input logic req, input logic wen, input logic [11:0] addr, input logic [15:0] id);
        req_i  = req;
        wen_i  = wen;
        addr_i = addr;
        id_i   = id;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 12'h000, 16'h0);
    endtask

    initial begin
        clear_i = 1'b0;
        done_i  = 1'b0;
        wdata_i = 32'h0;
        be_i    = 4'hF;
        idle();
        repeat (3) step();
        rst_ni = 1'b1;
        step();

        check_eq("rst_r_valid", r_valid_o, 0);
        check_eq("rst_start", start_o, 0);
        check_eq("rst_true_done", true_done_o, 0);
        check_eq("rst_evt", evt_o, 0);
        check_eq("rst_full", full_context_o, 0);
        check_eq("rst_pointer", pointer_context_o, 0);
        check_eq("rst_running", running_context_o, 0);
        check_eq("rst_gnt", gnt_o, 0);
        check_eq("rst_is_read", is_read_o, 0);

        // ACQUIRE from id 3
        bus(1, 1, 12'h004, 16'd3); #1;
        check_eq("acq_gnt", gnt_o, 1);
        check_eq("acq_testset", is_testset_o, 1);
        check_eq("acq_is_read", is_read_o, 1);
        check_eq("acq_rden", rf_rden_o, 1);
        check_eq("acq_wren", rf_wren_o, 0);
        check_eq("acq_critical", is_critical_o, 0);
        check_eq("acq_mandatory", is_mandatory_o, 1);
        step(); idle();
        check_eq("acq_r_valid", r_valid_o, 1);
        check_eq("acq_r_id", r_id_o, 3);

        // ACQUIRE from id 5 while id 3 holds the lock
        bus(1, 1, 12'h004, 16'd5); #1;
        check_eq("crit_critical", is_critical_o, 1);
        check_eq("crit_full", full_context_o, 0);
        step(); idle();
        check_eq("crit_r_id", r_id_o, 5);

        // Read idx 6: last mandatory register
        bus(1, 1, 12'h018, 16'd5); #1;
        check_eq("idx6_mandatory", is_mandatory_o, 1);
        check_eq("idx6_testset", is_testset_o, 0);
        check_eq("idx6_addr", rf_addr_o, 6);
        step();

        // Write idx 7 with context field 1: neither mandatory nor contexted
        bus(1, 0, 12'h09C, 16'd3);
        wdata_i = 32'hDEADBEEF;
        be_i    = 4'h5;
        #1;
        check_eq("idx7_mandatory", is_mandatory_o, 0);
        check_eq("idx7_contexted", is_contexted_o, 0);
        check_eq("idx7_addr", rf_addr_o, 39);
        check_eq("idx7_wren", rf_wren_o, 1);
        check_eq("idx7_wdata", rf_wdata_o, 32'hDEADBEEF);
        check_eq("idx7_be", rf_be_o, 4'h5);
        check_eq("idx7_src", rf_src_o, 3);
        step();
        be_i = 4'hF;

        // Contexted write ignores address context field, uses pointer 0
        bus(1, 0, 12'h0C0, 16'd3); #1;
        check_eq("io16_contexted", is_contexted_o, 1);
        check_eq("io16_addr_p0", rf_addr_o, 16);
        check_eq("io16_wren", rf_wren_o, 1);
        step();

        // TRIGGER by owner at t
        bus(1, 0, 12'h000, 16'd3); #1;
        check_eq("trig_is_trigger", is_trigger_o, 1);
        check_eq("trig_wren", rf_wren_o, 1);
        step(); idle();
        check_eq("trig_t1_pointer", pointer_context_o, 1);
        check_eq("trig_t1_start", start_o, 0);
        check_eq("trig_t1_r_valid", r_valid_o, 1);
        step();
        check_eq("trig_t2_start", start_o, 1);
        step();
        check_eq("trig_t3_start", start_o, 0);
        check_eq("trig_t3_full", full_context_o, 0);

        // Second job while engine is stalled in RUNNING
        bus(1, 1, 12'h004, 16'd3); #1;
        check_eq("acq2_critical", is_critical_o, 0);
        step();
        bus(1, 0, 12'h040, 16'd3); #1;
        check_eq("io16_addr_p1", rf_addr_o, 48);
        check_eq("io16_owner_wren", rf_wren_o, 1);
        step();
        bus(1, 0, 12'h040, 16'd9); #1;
`ifdef HWPE_CTRL_CTX_MGR_OWNER_CHECK_EN
        check_eq("io16_nonowner_wren", rf_wren_o, 0);
`else
        check_eq("io16_nonowner_wren", rf_wren_o, 1);
`endif
        step();
        bus(1, 0, 12'h000, 16'd3);
        check_eq("nonowner_r_valid", r_valid_o, 1);
        check_eq("nonowner_r_id", r_id_o, 9);
        step(); idle();
        check_eq("full_after_2", full_context_o, 1);
        check_eq("pointer_wrap", pointer_context_o, 0);

        // ACQUIRE while full and unlocked
        bus(1, 1, 12'h004, 16'd7); #1;
        check_eq("accfull_full", full_context_o, 1);
        check_eq("accfull_critical", is_critical_o, 0);
        check_eq("accfull_testset", is_testset_o, 1);
        step(); idle();
        check_eq("accfull_r_id", r_id_o, 7);

        // Retire one job; next start at t+3
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_eq("done1_true_done", true_done_o, 1);
        check_eq("done1_evt", evt_o, 1);
        check_eq("done1_running", running_context_o, 0);
        step();
        check_eq("done1_running_inc", running_context_o, 1);
        check_eq("done1_full", full_context_o, 0);
        check_eq("done1_true_done_off", true_done_o, 0);
        check_eq("done1_start_t2", start_o, 0);
        step();
        check_eq("done1_start_t3", start_o, 1);
        step();

        // Full ACQUIRE earlier must not have locked
        bus(1, 1, 12'h004, 16'd8); #1;
        check_eq("acq8_critical", is_critical_o, 0);
        step(); idle();

        // TRIGGER lands in the DONE cycle
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        bus(1, 0, 12'h000, 16'd8); #1;
        check_eq("done2_true_done", true_done_o, 1);
        check_eq("done2_is_trigger", is_trigger_o, 1);
        step(); idle();
        check_eq("done2_pointer", pointer_context_o, 1);
        check_eq("done2_running", running_context_o, 0);
        check_eq("done2_full", full_context_o, 0);
        step();
        check_eq("done2_start", start_o, 1);
        step();

        // Clear while RUNNING, then a stray done_i
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_eq("clr_pointer", pointer_context_o, 0);
        check_eq("clr_running", running_context_o, 0);
        check_eq("clr_full", full_context_o, 0);
        check_eq("clr_start", start_o, 0);
        check_eq("clr_r_valid", r_valid_o, 0);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_eq("clr_done_ignored", true_done_o, 0);
        check_eq("clr_evt_ignored", evt_o, 0);
        step();
        step();
        check_eq("clr_no_start", start_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
